// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, MUL/DIV tracker state type and register-index width helper
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  function automatic int reg_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/md_tracker.sv
// md_tracker: MUL/DIV busy FSM, latency counter, result destination and pending-register scoreboard
module md_tracker import hazard_pkg::*; #(
  parameter int NREG = 32,
  parameter int MD_LAT = 4,
  localparam int REG_AW = reg_aw(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_md_start_e,
  input  logic [REG_AW-1:0] i_rd_e,
  output logic              o_busy,
  output logic              o_md_write,
  output logic [REG_AW-1:0] o_md_rd,
  output logic [NREG-1:0]   o_pending
);
  localparam int CW = $clog2(MD_LAT) + 1;
  md_state_t         r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_md_write, w_md_write_n;
  logic [REG_AW-1:0] r_md_rd, w_md_rd_n;
  logic [NREG-1:0]   r_pending, w_pending_n, w_clr, w_set;
  logic              w_accept;
  // A new issue is taken when idle or in the write-back cycle, which frees the unit at its closing edge
  always_comb begin
    w_accept     = i_md_start_e & ((r_state == MD_IDLE) | r_md_write);
    w_state_n    = w_accept ? MD_BUSY : (r_md_write ? MD_IDLE : r_state);
    w_cnt_n      = w_accept ? CW'(MD_LAT - 1) : ((r_state == MD_BUSY && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt);
    w_md_write_n = (r_state == MD_BUSY) & (r_cnt == CW'(1));
    w_md_rd_n    = w_accept ? i_rd_e : r_md_rd;
    w_clr        = r_md_write ? (NREG'(1) << r_md_rd) : '0;
    w_set        = (w_accept && i_rd_e != '0) ? (NREG'(1) << i_rd_e) : '0;
    w_pending_n  = (r_pending & ~w_clr) | w_set;
  end
  // State register; reset drops any in-flight operation so no write appears after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= MD_IDLE;
      r_cnt      <= '0;
      r_md_write <= 1'b0;
      r_md_rd    <= '0;
      r_pending  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_md_write <= w_md_write_n;
      r_md_rd    <= w_md_rd_n;
      r_pending  <= w_pending_n;
    end
  end
  assign o_busy     = r_state == MD_BUSY;
  assign o_md_write = r_md_write;
  assign o_md_rd    = r_md_rd;
  assign o_pending  = r_pending;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, load-use/scoreboard/structural stalls and flushes for a pipeline with a multi-cycle MUL/DIV
// HAZARD_PERF_CNT_EN adds saturating stall, flush and MUL/DIV issue counters
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int NREG = 32,
  parameter int MD_LAT = 4,
  localparam int REG_AW = reg_aw(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rd_d,
  input  logic              i_md_start_d,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_result_src_e0,
  input  logic              i_md_start_e,
  input  logic              i_pc_src_e,
  input  logic              i_reg_write_m,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_reg_write_w,
  input  logic [REG_AW-1:0] i_rd_w,
  output logic [1:0]        o_forward_ae,
  output logic [1:0]        o_forward_be,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_md_write,
  output logic [REG_AW-1:0] o_md_rd
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt,
  output logic [31:0]       o_md_op_cnt
`endif
);
  logic [NREG-1:0] w_pending;
  logic            w_busy, w_lw_stall, w_sb_stall, w_md_stall, w_stall;
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] rs, input logic wm, input logic [REG_AW-1:0] rdm,
                                     input logic ww, input logic [REG_AW-1:0] rdw);
    return (wm && rdm != '0 && rdm == rs) ? FWD_M : ((ww && rdw != '0 && rdw == rs) ? FWD_W : FWD_RF);
  endfunction
  // A register is busy if already pending or being claimed by the MUL/DIV issuing this cycle
  function automatic logic sb_hit(input logic [REG_AW-1:0] r, input logic [NREG-1:0] p,
                                  input logic me, input logic [REG_AW-1:0] re);
    return (r != '0) && (p[r] || (me && r == re));
  endfunction
  md_tracker #(.NREG(NREG), .MD_LAT(MD_LAT)) u_md (
    .clk          (clk),
    .reset        (reset),
    .i_md_start_e (i_md_start_e),
    .i_rd_e       (i_rd_e),
    .o_busy       (w_busy),
    .o_md_write   (o_md_write),
    .o_md_rd      (o_md_rd),
    .o_pending    (w_pending)
  );
  // Operand forwarding from M (priority) then W; x0 is never forwarded
  always_comb begin
    o_forward_ae = fwd(i_rs1_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
    o_forward_be = fwd(i_rs2_e, i_reg_write_m, i_rd_m, i_reg_write_w, i_rd_w);
  end
  // Stalls are suppressed on a taken branch because the D instruction is on the wrong path
  always_comb begin
    w_lw_stall = i_result_src_e0 & (i_rd_e != '0) & ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));
    w_sb_stall = sb_hit(i_rs1_d, w_pending, i_md_start_e, i_rd_e) | sb_hit(i_rs2_d, w_pending, i_md_start_e, i_rd_e)
               | sb_hit(i_rd_d, w_pending, i_md_start_e, i_rd_e);
    w_md_stall = i_md_start_d & (w_busy | i_md_start_e);
    w_stall    = (w_lw_stall | w_sb_stall | w_md_stall) & ~i_pc_src_e;
    o_stall_f  = w_stall;
    o_stall_d  = w_stall;
    o_flush_d  = i_pc_src_e;
    o_flush_e  = w_stall | i_pc_src_e;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt, r_md_op_cnt;
  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_md_op_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(o_stall_d && r_stall_cnt != '1);
      r_flush_cnt <= r_flush_cnt + 32'(o_flush_e && !w_stall && r_flush_cnt != '1);
      r_md_op_cnt <= r_md_op_cnt + 32'(i_md_start_e && r_md_op_cnt != '1);
    end
  end
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_md_op_cnt = r_md_op_cnt;
`endif
endmodule
